// File: rtl/aes_key_pkg.sv
// Purpose: shared types and constants for the AES key RAM loader.
//   state_e   - loader sequencing states
//   CMD_*     - bit positions inside the 16-bit command/status field
//   ACK_*     - write data byte and byte enable used to acknowledge a key
package aes_key_pkg;

    localparam int unsigned KEY_W  = 128;
    localparam int unsigned BE_W   = KEY_W / 8;
    localparam int unsigned ADDR_W = 2;
    localparam int unsigned SEQ_W  = 8;

    localparam int unsigned CMD_VALID_BIT = 0;
    localparam int unsigned CMD_DONE_BIT  = 1;
    localparam int unsigned CMD_SEQ_LSB   = 8;
    localparam int unsigned CMD_SEQ_MSB   = 15;

    // Acknowledge writes only byte0: VALID cleared, DONE set, SEQ byte untouched
    localparam logic [7:0]      ACK_BYTE = 8'(1 << CMD_DONE_BIT);
    localparam logic [BE_W-1:0] ACK_BE   = BE_W'(1);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        POLL_RD  = 3'd1,
        POLL_CHK = 3'd2,
        KEY_RD   = 3'd3,
        KEY_CAP  = 3'd4,
        PRESENT  = 3'd5,
        ACK_WR   = 3'd6
    } state_e;

endpackage

// File: rtl/aes_key_ram_loader.sv
// Purpose: sole master of port 2 of the 4x128b HPS key RAM. Periodically
// polls the command word, fetches a new key when VALID is set with a fresh
// sequence number, offers it to the AES core over valid/ready, then writes
// DONE back into the command word.
// Ports:
//   clk, reset_n           clock, asynchronous active-low reset
//   enable                 allow polling (an in-flight load always completes)
//   ram_*                  RAM port 2 (registered address, unregistered q)
//   key_data/valid/ready   key handoff to the AES key expansion
//   key_seq, load_count    sequence of last accepted key, keys accepted
//   busy                   high whenever the loader is not idle
module aes_key_ram_loader
    import aes_key_pkg::*;
#(
    parameter int unsigned KEY_ADDR    = 0,
    parameter int unsigned CMD_ADDR    = 3,
    parameter int unsigned POLL_CYCLES = 64,
    parameter int unsigned CNT_W       = 8
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              enable,
    output logic [ADDR_W-1:0] ram_address,
    output logic              ram_chipselect,
    output logic              ram_write,
    output logic [KEY_W-1:0]  ram_writedata,
    output logic [BE_W-1:0]   ram_byteenable,
    output logic              ram_clken,
    input  logic [KEY_W-1:0]  ram_readdata,
    output logic [KEY_W-1:0]  key_data,
    output logic              key_valid,
    input  logic              key_ready,
    output logic [SEQ_W-1:0]  key_seq,
    output logic [CNT_W-1:0]  load_count,
    output logic              busy
);

    localparam logic [CNT_W-1:0]  TIMER_LAST = CNT_W'(POLL_CYCLES - 1);
    localparam logic [ADDR_W-1:0] KEY_A      = ADDR_W'(KEY_ADDR);
    localparam logic [ADDR_W-1:0] CMD_A      = ADDR_W'(CMD_ADDR);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   timer_q, timer_d;
    logic [SEQ_W-1:0]   pend_seq_q, pend_seq_d;
    logic [KEY_W-1:0]   key_data_q, key_data_d;
    logic               key_valid_q, key_valid_d;
    logic [SEQ_W-1:0]   key_seq_q, key_seq_d;
    logic [CNT_W-1:0]   load_count_q, load_count_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic               cs_q, cs_d;
    logic               wr_q, wr_d;
    logic [KEY_W-1:0]   wdata_q, wdata_d;
    logic [BE_W-1:0]    be_q, be_d;
    logic               busy_q, busy_d;

    logic               cmd_valid_c;
    logic [SEQ_W-1:0]   cmd_seq_c;

    assign cmd_valid_c = ram_readdata[CMD_VALID_BIT];
    assign cmd_seq_c   = ram_readdata[CMD_SEQ_MSB:CMD_SEQ_LSB];

    // Next state, datapath and registered RAM-port/status outputs
    always_comb begin
        state_d      = state_q;
        timer_d      = timer_q;
        pend_seq_d   = pend_seq_q;
        key_data_d   = key_data_q;
        key_valid_d  = key_valid_q;
        key_seq_d    = key_seq_q;
        load_count_d = load_count_q;
        addr_d       = '0;
        cs_d         = 1'b0;
        wr_d         = 1'b0;
        wdata_d      = '0;
        be_d         = '0;

        unique case (state_q)
            IDLE: begin
                if (!enable) begin
                    timer_d = '0;
                end else if (timer_q == TIMER_LAST) begin
                    timer_d = '0;
                    state_d = POLL_RD;
                end else begin
                    timer_d = timer_q + CNT_W'(1);
                end
            end
            POLL_RD:  state_d = POLL_CHK;
            POLL_CHK: begin
                // A first load after reset accepts any sequence number
                if (cmd_valid_c && ((cmd_seq_c != key_seq_q) || (load_count_q == '0))) begin
                    pend_seq_d = cmd_seq_c;
                    state_d    = KEY_RD;
                end else begin
                    state_d = IDLE;
                end
            end
            KEY_RD:   state_d = KEY_CAP;
            KEY_CAP: begin
                key_data_d  = ram_readdata;
                key_valid_d = 1'b1;
                state_d     = PRESENT;
            end
            PRESENT: begin
                if (key_valid_q && key_ready) begin
                    key_valid_d  = 1'b0;
                    key_seq_d    = pend_seq_q;
                    load_count_d = load_count_q + CNT_W'(1);
                    state_d      = ACK_WR;
                end
            end
            ACK_WR:   state_d = IDLE;
            default:  state_d = IDLE;
        endcase

        // RAM port outputs are decoded from the state being entered so they
        // line up with that state's cycle once registered
        unique case (state_d)
            POLL_RD: begin
                addr_d = CMD_A;
                cs_d   = 1'b1;
            end
            KEY_RD: begin
                addr_d = KEY_A;
                cs_d   = 1'b1;
            end
            ACK_WR: begin
                addr_d  = CMD_A;
                cs_d    = 1'b1;
                wr_d    = 1'b1;
                be_d    = ACK_BE;
                wdata_d = KEY_W'(ACK_BYTE);
            end
            default: ;
        endcase

        busy_d = (state_d != IDLE);
    end

    // State and output registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            timer_q      <= '0;
            pend_seq_q   <= '0;
            key_data_q   <= '0;
            key_valid_q  <= 1'b0;
            key_seq_q    <= '0;
            load_count_q <= '0;
            addr_q       <= '0;
            cs_q         <= 1'b0;
            wr_q         <= 1'b0;
            wdata_q      <= '0;
            be_q         <= '0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            timer_q      <= timer_d;
            pend_seq_q   <= pend_seq_d;
            key_data_q   <= key_data_d;
            key_valid_q  <= key_valid_d;
            key_seq_q    <= key_seq_d;
            load_count_q <= load_count_d;
            addr_q       <= addr_d;
            cs_q         <= cs_d;
            wr_q         <= wr_d;
            wdata_q      <= wdata_d;
            be_q         <= be_d;
            busy_q       <= busy_d;
        end
    end

    assign ram_address    = addr_q;
    assign ram_chipselect = cs_q;
    assign ram_write      = wr_q;
    assign ram_writedata  = wdata_q;
    assign ram_byteenable = be_q;
    assign ram_clken      = 1'b1;
    assign key_data       = key_data_q;
    assign key_valid      = key_valid_q;
    assign key_seq        = key_seq_q;
    assign load_count     = load_count_q;
    assign busy           = busy_q;

endmodule

// File: tb/tb_aes_key_ram_loader.sv
// Testbench for aes_key_ram_loader: models the dual-port key RAM (HPS side
// plus port 2), keeps a transaction-level reference of what the loader must
// present, and compares every cycle, alongside directed literal checks.
module tb_aes_key_ram_loader;

    localparam int POLL = 64;

    logic         clk = 1'b0;
    logic         reset_n;
    logic         enable;
    logic [1:0]   ram_address;
    logic         ram_chipselect;
    logic         ram_write;
    logic [127:0] ram_writedata;
    logic [15:0]  ram_byteenable;
    logic         ram_clken;
    logic [127:0] ram_readdata;
    logic [127:0] key_data;
    logic         key_valid;
    logic         key_ready;
    logic [7:0]   key_seq;
    logic [7:0]   load_count;
    logic         busy;

    aes_key_ram_loader #(
        .KEY_ADDR(0), .CMD_ADDR(3), .POLL_CYCLES(POLL), .CNT_W(8)
    ) dut (
        .clk(clk), .reset_n(reset_n), .enable(enable),
        .ram_address(ram_address), .ram_chipselect(ram_chipselect),
        .ram_write(ram_write), .ram_writedata(ram_writedata),
        .ram_byteenable(ram_byteenable), .ram_clken(ram_clken),
        .ram_readdata(ram_readdata), .key_data(key_data),
        .key_valid(key_valid), .key_ready(key_ready), .key_seq(key_seq),
        .load_count(load_count), .busy(busy)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- RAM model: HPS port + port 2 ----------------
    logic [127:0] mem [4];
    logic [1:0]   mem_addr_q = 2'd0;
    logic         hps_we = 1'b0;
    logic [1:0]   hps_addr = 2'd0;
    logic [127:0] hps_wdata = '0;
    logic [15:0]  hps_be = '0;

    always @(posedge clk) begin
        if (ram_clken) mem_addr_q <= ram_address;
        for (int b = 0; b < 16; b++) begin
            if (ram_clken && ram_chipselect && ram_write && ram_byteenable[b])
                mem[ram_address][b*8 +: 8] <= ram_writedata[b*8 +: 8];
            if (hps_we && hps_be[b])
                mem[hps_addr][b*8 +: 8] <= hps_wdata[b*8 +: 8];
        end
    end
    assign ram_readdata = mem[mem_addr_q];

    task automatic hps_write(input logic [1:0] a, input logic [127:0] d, input logic [15:0] be);
        hps_addr  = a;
        hps_wdata = d;
        hps_be    = be;
        hps_we    = 1'b1;
        @(negedge clk);
        hps_we    = 1'b0;
    endtask

    // ---------------- Reference model ----------------
    // m_phase: -1 idle, otherwise cycles since the command read was issued
    // (0 cmd read, 1 decide, 2 key read, 3 capture, 4 presenting).
    int           m_phase;
    int           m_idle;
    logic         m_ack;
    logic         m_kv;
    logic [127:0] m_kd;
    logic [7:0]   m_seq;
    logic [7:0]   m_pend;
    logic [7:0]   m_cnt;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_phase <= -1; m_idle <= 0; m_ack <= 1'b0; m_kv <= 1'b0;
            m_kd <= '0; m_seq <= '0; m_pend <= '0; m_cnt <= '0;
        end else if (m_ack) begin
            m_ack  <= 1'b0;
            m_idle <= 0;
        end else if (m_phase < 0) begin
            if (!enable) m_idle <= 0;
            else if (m_idle == POLL - 1) begin
                m_idle  <= 0;
                m_phase <= 0;
            end else m_idle <= m_idle + 1;
        end else if (m_phase == 1) begin
            if (mem[3][0] && (mem[3][15:8] != m_seq || m_cnt == 8'd0)) begin
                m_pend  <= mem[3][15:8];
                m_phase <= 2;
            end else m_phase <= -1;
        end else if (m_phase == 3) begin
            m_kd    <= mem[0];
            m_kv    <= 1'b1;
            m_phase <= 4;
        end else if (m_phase == 4) begin
            if (key_ready) begin
                m_kv    <= 1'b0;
                m_seq   <= m_pend;
                m_cnt   <= m_cnt + 8'd1;
                m_ack   <= 1'b1;
                m_phase <= -1;
            end
        end else m_phase <= m_phase + 1;
    end

    // Per-cycle comparison against the model
    always @(negedge clk) begin
        if (reset_n) begin
            logic       e_cs;
            logic [1:0] e_addr;
            e_cs   = (m_phase == 0) || (m_phase == 2) || m_ack;
            e_addr = (m_phase == 2) ? 2'd0 : (e_cs ? 2'd3 : 2'd0);
            check("key_valid", 128'(key_valid), 128'(m_kv));
            check("key_data", key_data, m_kd);
            check("key_seq", 128'(key_seq), 128'(m_seq));
            check("load_count", 128'(load_count), 128'(m_cnt));
            check("busy", 128'(busy), 128'((m_phase >= 0) || m_ack));
            check("ram_cs", 128'(ram_chipselect), 128'(e_cs));
            check("ram_addr", 128'(ram_address), 128'(e_addr));
            check("ram_write", 128'(ram_write), 128'(m_ack));
            check("ram_be", 128'(ram_byteenable), m_ack ? 128'h1 : 128'h0);
            check("ram_wdata", ram_writedata, m_ack ? 128'h2 : 128'h0);
            check("ram_clken", 128'(ram_clken), 128'(1));
        end
    end

    // Event monitors
    int   mon_polls = 0;
    int   mon_writes = 0;
    int   mon_kv_rises = 0;
    logic kv_prev = 1'b0;
    always @(negedge clk) begin
        if (ram_chipselect && !ram_write && ram_address == 2'd3) mon_polls++;
        if (ram_chipselect && ram_write) mon_writes++;
        if (key_valid && !kv_prev) mon_kv_rises++;
        kv_prev = key_valid;
    end

    // ---------------- Helpers ----------------
    task automatic wait_poll(input int max, output int n);
        logic seen;
        n = 0;
        seen = 1'b0;
        while (!seen && n < max) begin
            @(negedge clk);
            n++;
            seen = ram_chipselect && !ram_write && (ram_address == 2'd3);
        end
        check("poll_seen", 128'(seen), 128'(1));
    endtask

    task automatic wait_kv(input int max, output int n);
        n = 0;
        while (!key_valid && n < max) begin
            @(negedge clk);
            n++;
        end
        check("key_valid_seen", 128'(key_valid), 128'(1));
    endtask

    task automatic load_key(input logic [127:0] k, input logic [7:0] seq);
        int n;
        hps_write(2'd0, k, 16'hFFFF);
        hps_write(2'd3, {112'd0, seq, 8'h01}, 16'h0003);
        wait_poll(POLL + 8, n);
        wait_kv(8, n);
        check("latency_poll_to_valid", 128'(n), 128'(4));
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    localparam logic [127:0] KEY1 = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] KEY2 = 128'h112233445566778899aabbccddeeff00;
    localparam logic [127:0] KEY3 = 128'hdeadbeef0badf00dcafebabe12345678;
    localparam logic [127:0] KEY4 = 128'h0f0e0d0c0b0a09080706050403020100;
    localparam logic [127:0] KEY5 = 128'ha5a5a5a55a5a5a5affff000000ffff11;

    initial begin
        int n;
        int nb;
        int snap_kv;
        int snap_wr;
        int snap_polls;
        reset_n   = 1'b0;
        enable    = 1'b1;
        key_ready = 1'b0;
        for (int a = 0; a < 4; a++) hps_write(2'(a), '0, 16'hFFFF);
        repeat (2) @(negedge clk);

        // Reset values
        check("rst_key_valid", 128'(key_valid), 128'(0));
        check("rst_busy", 128'(busy), 128'(0));
        check("rst_load_count", 128'(load_count), 128'(0));
        check("rst_key_seq", 128'(key_seq), 128'(0));
        check("rst_cs", 128'(ram_chipselect), 128'(0));
        check("rst_clken", 128'(ram_clken), 128'(1));
        #2 reset_n = 1'b1;

        // Test 1: empty command word, periodic polls, 2-cycle busy pulse
        wait_poll(POLL + 8, n);
        check("first_poll_cycle", 128'(n), 128'(64));
        n = 0; nb = 1;
        begin
            logic seen;
            seen = 1'b0;
            while (!seen && n < 200) begin
                @(negedge clk);
                n++;
                seen = ram_chipselect && !ram_write && (ram_address == 2'd3);
                if (!seen && busy) nb++;
            end
        end
        check("poll_period", 128'(n), 128'(66));
        check("busy_pulse_len", 128'(nb), 128'(2));
        check("t1_no_valid", 128'(mon_kv_rises), 128'(0));
        check("t1_no_writes", 128'(mon_writes), 128'(0));

        // Test 2: load with immediate accept
        key_ready = 1'b1;
        load_key(KEY1, 8'h05);
        check("t2_key_data", key_data, KEY1);
        @(negedge clk);
        check("t2_ack_write", 128'(ram_write), 128'(1));
        @(negedge clk);
        check("t2_key_seq", 128'(key_seq), 128'(8'h05));
        check("t2_load_count", 128'(load_count), 128'(1));
        check("t2_cmd_word", 128'(mem[3][15:0]), 128'(16'h0502));

        // Test 4: same SEQ rewritten -> no reload; new SEQ -> reload
        snap_kv = mon_kv_rises;
        snap_wr = mon_writes;
        hps_write(2'd3, 128'h0501, 16'h0003);
        wait_poll(POLL + 8, n);
        wait_poll(POLL + 8, n);
        repeat (3) @(negedge clk);
        check("t4_no_reload_valid", 128'(mon_kv_rises), 128'(snap_kv));
        check("t4_no_reload_write", 128'(mon_writes), 128'(snap_wr));
        check("t4_count_kept", 128'(load_count), 128'(1));
        load_key(KEY2, 8'h06);
        check("t4_key_data", key_data, KEY2);
        repeat (2) @(negedge clk);
        check("t4_key_seq", 128'(key_seq), 128'(8'h06));
        check("t4_load_count", 128'(load_count), 128'(2));

        // Test 3: backpressure for 20 cycles, accepted in cycle 21
        key_ready = 1'b0;
        load_key(KEY3, 8'h07);
        nb = 1;
        for (int i = 2; i <= 21; i++) begin
            @(negedge clk);
            if (key_valid && key_data == KEY3) nb++;
            if (i == 21) key_ready = 1'b1;
        end
        check("t3_hold_cycles", 128'(nb), 128'(21));
        @(negedge clk);
        check("t3_valid_dropped", 128'(key_valid), 128'(0));
        check("t3_load_count", 128'(load_count), 128'(3));
        check("t3_key_seq", 128'(key_seq), 128'(8'h07));

        // Test 5: enable dropped while presenting
        key_ready = 1'b0;
        load_key(KEY4, 8'h08);
        enable = 1'b0;
        repeat (3) @(negedge clk);
        check("t5_still_valid", 128'(key_valid), 128'(1));
        key_ready = 1'b1;
        @(negedge clk);
        check("t5_ack_write", 128'(ram_write), 128'(1));
        @(negedge clk);
        check("t5_cmd_word", 128'(mem[3][15:0]), 128'(16'h0802));
        check("t5_load_count", 128'(load_count), 128'(4));
        snap_polls = mon_polls;
        repeat (200) @(negedge clk);
        check("t5_no_polls", 128'(mon_polls), 128'(snap_polls));
        check("t5_idle", 128'(busy), 128'(0));
        enable = 1'b1;
        wait_poll(POLL + 8, n);
        check("t5_poll_after_enable", 128'(n), 128'(64));

        // Test 6: reset in PRESENT
        repeat (3) @(negedge clk);
        key_ready = 1'b0;
        load_key(KEY5, 8'h09);
        repeat (2) @(negedge clk);
        #2 reset_n = 1'b0;
        #1;
        check("t6_async_valid", 128'(key_valid), 128'(0));
        check("t6_async_busy", 128'(busy), 128'(0));
        check("t6_async_cs", 128'(ram_chipselect), 128'(0));
        check("t6_async_count", 128'(load_count), 128'(0));
        repeat (2) @(negedge clk);
        check("t6_cmd_kept", 128'(mem[3][15:0]), 128'(16'h0901));
        #2 reset_n = 1'b1;
        key_ready = 1'b1;
        wait_poll(POLL + 8, n);
        check("t6_poll_after_reset", 128'(n), 128'(64));
        wait_kv(8, n);
        check("t6_key_data", key_data, KEY5);
        repeat (2) @(negedge clk);
        check("t6_key_seq", 128'(key_seq), 128'(8'h09));
        check("t6_load_count", 128'(load_count), 128'(1));
        check("t6_cmd_done", 128'(mem[3][15:0]), 128'(16'h0902));

        // load_count wrap: 255 more loads bring 1 back to 0
        for (int j = 0; j < 255; j++) begin
            load_key(KEY1 ^ 128'(j), 8'(10 + j));
            repeat (2) @(negedge clk);
        end
        check("wrap_load_count", 128'(load_count), 128'(0));
        check("wrap_key_seq", 128'(key_seq), 128'(8'(10 + 254)));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
